// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU has fixed priority, DMA gets a forced slot after MAX_WAIT denials.
// Optional bus lock for the DMA master is built when DMEM_ARBITER_LOCK_EN is defined.
module dmem_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
`ifdef DMEM_ARBITER_LOCK_EN
    input  logic          dma_lock,
`endif
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_DMA
    } owner_t;

    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    logic [3:0] waitCnt_q;
    logic [3:0] waitCnt_d;
    owner_t     rdOwner_q;
    owner_t     rdOwner_d;
    logic       lockActive;
    logic       forceDma;
    logic       cpuGnt;
    logic       dmaGnt;

`ifdef DMEM_ARBITER_LOCK_EN
    typedef enum logic {
        ARB,
        LOCK
    } state_t;

    state_t state_q;

    // Lock only overrides arbitration while dma_lock is still held; the release cycle is normal.
    assign lockActive = (state_q == LOCK) && dma_lock;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
        end else begin
            case (state_q)
                ARB:     if (dmaGnt && dma_lock) state_q <= LOCK;
                LOCK:    if (!dma_lock) state_q <= ARB;
                default: state_q <= ARB;
            endcase
        end
    end
`else
    assign lockActive = 1'b0;
`endif

    always_comb begin
        forceDma = dma_req && (waitCnt_q == MaxWait);
        cpuGnt   = 1'b0;
        dmaGnt   = 1'b0;
        if (!rst) begin
            if (lockActive) begin
                dmaGnt = dma_req;
            end else if (cpu_req && !forceDma) begin
                cpuGnt = 1'b1;
            end else if (dma_req) begin
                dmaGnt = 1'b1;
            end
        end
    end

    always_comb begin
        waitCnt_d = waitCnt_q;
        if (lockActive || !dma_req || dmaGnt) begin
            waitCnt_d = '0;
        end else if (waitCnt_q < MaxWait) begin
            waitCnt_d = waitCnt_q + 4'd1;
        end
    end

    always_comb begin
        rdOwner_d = OWN_NONE;
        if (cpuGnt && !cpu_we) begin
            rdOwner_d = OWN_CPU;
        end else if (dmaGnt && !dma_we) begin
            rdOwner_d = OWN_DMA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            waitCnt_q <= '0;
            rdOwner_q <= OWN_NONE;
        end else begin
            waitCnt_q <= waitCnt_d;
            rdOwner_q <= rdOwner_d;
        end
    end

    assign cpu_gnt = cpuGnt;
    assign dma_gnt = dmaGnt;
    assign mem_en  = cpuGnt | dmaGnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpuGnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dmaGnt) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    // The owner register can still hold a stale read while reset is asserted, so gate it.
    assign cpu_rvalid = !rst && (rdOwner_q == OWN_CPU);
    assign dma_rvalid = !rst && (rdOwner_q == OWN_DMA);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter; exercises the lock path when DMEM_ARBITER_LOCK_EN is set.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic        mem_en, mem_we;
    logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
`ifdef DMEM_ARBITER_LOCK_EN
    logic        dma_lock;
`endif

    int compareCount;
    int mismatchCount;

    dmem_arbiter #(.AW(16), .DW(16), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
`ifdef DMEM_ARBITER_LOCK_EN
        .dma_lock(dma_lock),
`endif
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
    task automatic applyStimulus(input logic cReq, input logic cWe, input logic [15:0] cAddr,
                                 input logic [15:0] cWdata, input logic dReq, input logic dWe,
                                 input logic [15:0] dAddr, input logic [15:0] dWdata,
                                 input logic [15:0] mRdata);
        @(negedge clk);
        cpu_req   = cReq;
        cpu_we    = cWe;
        cpu_addr  = cAddr;
        cpu_wdata = cWdata;
        dma_req   = dReq;
        dma_we    = dWe;
        dma_addr  = dAddr;
        dma_wdata = dWdata;
        mem_rdata = mRdata;
        #1;
    endtask

    initial begin
        logic prevCpuRd;
        logic prevDmaRd;
        logic expDma;
        compareCount  = 0;
        mismatchCount = 0;
        rst = 1'b1;
`ifdef DMEM_ARBITER_LOCK_EN
        dma_lock = 1'b0;
`endif

        // Reset with both masters requesting: nothing may be granted.
        applyStimulus(1, 0, 16'h0010, 16'h0, 1, 0, 16'h0020, 16'h0, 16'h1111);
        applyStimulus(1, 0, 16'h0010, 16'h0, 1, 0, 16'h0020, 16'h0, 16'h1111);
        checkOutput("rst_cpu_gnt", cpu_gnt, 0);
        checkOutput("rst_dma_gnt", dma_gnt, 0);
        checkOutput("rst_mem_en", mem_en, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_cpu_rvalid", cpu_rvalid, 0);
        checkOutput("rst_dma_rdata", dma_rdata, 0);

        // CPU-only read.
        rst = 1'b0;
        applyStimulus(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0);
        checkOutput("cpu_rd_gnt", cpu_gnt, 1);
        checkOutput("cpu_rd_dma_gnt", dma_gnt, 0);
        checkOutput("cpu_rd_mem_en", mem_en, 1);
        checkOutput("cpu_rd_mem_we", mem_we, 0);
        checkOutput("cpu_rd_mem_addr", mem_addr, 16'h0010);
        applyStimulus(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 16'hBEEF);
        checkOutput("cpu_rd_rvalid", cpu_rvalid, 1);
        checkOutput("cpu_rd_rdata", cpu_rdata, 16'hBEEF);
        checkOutput("cpu_rd_dma_rvalid", dma_rvalid, 0);
        checkOutput("cpu_rd_dma_rdata", dma_rdata, 0);
        checkOutput("cpu_rd_idle_en", mem_en, 0);

        // Continuous contention: four CPU slots, then one forced DMA slot.
        prevCpuRd = 1'b0;
        prevDmaRd = 1'b0;
        for (int i = 0; i < 10; i++) begin
            expDma = ((i % 5) == 4);
            applyStimulus(1, 0, 16'h0020, 16'h0, 1, 0, 16'h0030, 16'h0, 16'hA000 + 16'(i));
            checkOutput($sformatf("cont%0d_cpu_gnt", i), cpu_gnt, !expDma);
            checkOutput($sformatf("cont%0d_dma_gnt", i), dma_gnt, expDma);
            checkOutput($sformatf("cont%0d_addr", i), mem_addr, expDma ? 16'h0030 : 16'h0020);
            checkOutput($sformatf("cont%0d_cpu_rv", i), cpu_rvalid, prevCpuRd);
            checkOutput($sformatf("cont%0d_dma_rv", i), dma_rvalid, prevDmaRd);
            checkOutput($sformatf("cont%0d_cpu_rd", i), cpu_rdata, prevCpuRd ? 16'hA000 + 16'(i) : 16'h0);
            prevCpuRd = !expDma;
            prevDmaRd = expDma;
        end

        // Idle: last contention slot was a DMA read; no grant means zero write data.
        applyStimulus(0, 1, 16'h0050, 16'h5555, 0, 0, 16'h0, 16'h0, 16'h7777);
        checkOutput("idle_dma_rv", dma_rvalid, 1);
        checkOutput("idle_dma_rd", dma_rdata, 16'h7777);
        checkOutput("idle_cpu_rv", cpu_rvalid, 0);
        checkOutput("idle_mem_en", mem_en, 0);
        checkOutput("idle_mem_wdata", mem_wdata, 0);
        checkOutput("idle_mem_addr", mem_addr, 0);

        // Alternating owners on back-to-back reads.
        applyStimulus(1, 0, 16'h0001, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0);
        checkOutput("alt0_cpu_gnt", cpu_gnt, 1);
        checkOutput("alt0_addr", mem_addr, 16'h0001);
        applyStimulus(0, 0, 16'h0, 16'h0, 1, 0, 16'h0002, 16'h0, 16'h1111);
        checkOutput("alt1_dma_gnt", dma_gnt, 1);
        checkOutput("alt1_addr", mem_addr, 16'h0002);
        checkOutput("alt1_cpu_rv", cpu_rvalid, 1);
        checkOutput("alt1_cpu_rd", cpu_rdata, 16'h1111);
        checkOutput("alt1_dma_rv", dma_rvalid, 0);
        applyStimulus(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h2222);
        checkOutput("alt2_dma_rv", dma_rvalid, 1);
        checkOutput("alt2_dma_rd", dma_rdata, 16'h2222);
        checkOutput("alt2_cpu_rv", cpu_rvalid, 0);
        checkOutput("alt2_cpu_rd", cpu_rdata, 0);

        // DMA write: strobes driven, no read data returned.
        applyStimulus(0, 0, 16'h0, 16'h0, 1, 1, 16'h0100, 16'h1234, 16'h0);
        checkOutput("wr_dma_gnt", dma_gnt, 1);
        checkOutput("wr_mem_en", mem_en, 1);
        checkOutput("wr_mem_we", mem_we, 1);
        checkOutput("wr_mem_addr", mem_addr, 16'h0100);
        checkOutput("wr_mem_wdata", mem_wdata, 16'h1234);
        applyStimulus(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h3333);
        checkOutput("wr_next_cpu_rv", cpu_rvalid, 0);
        checkOutput("wr_next_dma_rv", dma_rvalid, 0);

        // Dropping dma_req clears the wait counter.
        applyStimulus(1, 1, 16'h0060, 16'h0, 1, 1, 16'h0070, 16'h0, 16'h0);
        applyStimulus(1, 1, 16'h0060, 16'h0, 1, 1, 16'h0070, 16'h0, 16'h0);
        applyStimulus(1, 1, 16'h0060, 16'h0, 0, 1, 16'h0070, 16'h0, 16'h0);
        checkOutput("wd_cpu_gnt", cpu_gnt, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 16'h0060, 16'h0, 1, 1, 16'h0070, 16'h0, 16'h0);
            checkOutput($sformatf("wd%0d_dma_gnt", i), dma_gnt, i == 4);
        end

        // Build up waiting, then reset one cycle after a CPU read grant.
        applyStimulus(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 16'h0040, 16'h0, 1, 0, 16'h0080, 16'h0, 16'h0);
            checkOutput($sformatf("pre%0d_cpu_gnt", i), cpu_gnt, 1);
        end
        @(negedge clk);
        rst       = 1'b1;
        mem_rdata = 16'h9999;
        #1;
        checkOutput("mid_rst_cpu_rv", cpu_rvalid, 0);
        checkOutput("mid_rst_cpu_rd", cpu_rdata, 0);
        checkOutput("mid_rst_cpu_gnt", cpu_gnt, 0);
        checkOutput("mid_rst_dma_gnt", dma_gnt, 0);
        checkOutput("mid_rst_mem_en", mem_en, 0);
        checkOutput("mid_rst_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_cpu_rv", cpu_rvalid, 0);
        checkOutput("post_rst_dma_rv", dma_rvalid, 0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) applyStimulus(1, 0, 16'h0040, 16'h0, 1, 0, 16'h0080, 16'h0, 16'h0);
            checkOutput($sformatf("post%0d_dma_gnt", i), dma_gnt, i == 4);
            checkOutput($sformatf("post%0d_cpu_gnt", i), cpu_gnt, i != 4);
        end

`ifdef DMEM_ARBITER_LOCK_EN
        // Lock: CPU is shut out while dma_lock is held, released in the same cycle it drops.
        applyStimulus(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0);
        dma_lock = 1'b1;
        applyStimulus(0, 0, 16'h0, 16'h0, 1, 1, 16'h0200, 16'hAAAA, 16'h0);
        checkOutput("lock_dma_gnt", dma_gnt, 1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, 16'h0300, 16'h0, (i % 2) == 1, 1, 16'h0200, 16'hAAAA, 16'h0);
            checkOutput($sformatf("lock%0d_cpu_gnt", i), cpu_gnt, 0);
            checkOutput($sformatf("lock%0d_dma_gnt", i), dma_gnt, (i % 2) == 1);
        end
        @(negedge clk);
        dma_lock = 1'b0;
        dma_req  = 1'b0;
        #1;
        checkOutput("unlock_cpu_gnt", cpu_gnt, 1);
        checkOutput("unlock_mem_addr", mem_addr, 16'h0300);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
